// File: rtl/ks_ctrl_pkg.sv
// Shared types and constants for the Kogge-Stone adder sharing controller.
package ks_ctrl_pkg;

  localparam int unsigned ADDER_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} ks_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/n_bit_pg_Kogge_Stone_A.sv
// N-bit Kogge-Stone prefix adder with carry-in folded into bit 0 generate.
module n_bit_pg_Kogge_Stone_A #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned LOG = $clog2(N);

  logic [N-1:0] prop;
  logic [N-1:0] g [LOG+1];
  logic [N-1:0] p [LOG+1];

  always_comb begin
    prop    = a ^ b;
    g[0]    = a & b;
    g[0][0] = (a[0] & b[0]) | (prop[0] & cin);
    p[0]    = prop;
    for (int s = 0; s < int'(LOG); s++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (i >= (1 << s)) begin
          g[s+1][i] = g[s][i] | (p[s][i] & g[s][i-(1<<s)]);
          p[s+1][i] = p[s][i] & p[s][i-(1<<s)];
        end else begin
          g[s+1][i] = g[s][i];
          p[s+1][i] = p[s][i];
        end
      end
    end
  end

  // Group generate over [i:0] already includes cin, so it is the carry into bit i+1.
  assign sum  = prop ^ {g[LOG][N-2:0], cin};
  assign cout = g[LOG][N-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest set request at or after ptr wins.
module rr_arbiter import ks_ctrl_pkg::*; #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [2*NREQ-1:0] dbl;
  logic [IDW:0]      pos;

  always_comb begin
    dbl       = {req, req} >> ptr;
    pos       = '0;
    grant     = '0;
    grant_idx = '0;
    // Scan downwards so the nearest request to ptr is the last one written.
    for (int j = int'(NREQ) - 1; j >= 0; j--) begin
      if (dbl[j]) pos = {1'b0, ptr} + (IDW+1)'(j);
    end
    if (|req) begin
      grant_idx = (pos >= (IDW+1)'(NREQ)) ? IDW'(pos - (IDW+1)'(NREQ)) : IDW'(pos);
      grant     = NREQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/ks_adder_share_ctrl.sv
// Shares one 32-bit Kogge-Stone adder among NREQ requesters; multi-word adds run
// word-serially with a registered carry and return a tagged result.
module ks_adder_share_ctrl import ks_ctrl_pkg::*; #(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WORDS = 2,
  localparam int unsigned IDW   = id_width(NREQ),
  localparam int unsigned W     = ADDER_W * WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  localparam int unsigned KW = id_width(WORDS);

  ks_state_t state_q, state_d;

  logic [IDW-1:0]                  ptr_q, id_q, ptr_nxt;
  logic [KW-1:0]                   k_q;
  logic [WORDS-1:0][ADDER_W-1:0]   a_q, b_q, sum_q;
  logic                            cin_q, carry_q;
  logic [NREQ-1:0]                 grant;
  logic [IDW-1:0]                  grant_idx;
  logic [W-1:0]                    a_sel, b_sel;
  logic                            cin_sel, add_cin, add_cout, k_last;
  logic [ADDER_W-1:0]              add_sum;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        a_sel   = req_a[i*W +: W];
        b_sel   = req_b[i*W +: W];
        cin_sel = req_cin[i];
      end
    end
  end

  assign ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
  assign k_last  = (k_q == KW'(WORDS - 1));
  assign add_cin = (k_q == '0) ? cin_q : carry_q;

  n_bit_pg_Kogge_Stone_A #(
    .N (ADDER_W)
  ) u_adder (
    .a    (a_q[k_q]),
    .b    (b_q[k_q]),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_ready) state_d = BUSY;
      BUSY:    if (k_last)     state_d = DONE;
      DONE:    if (rsp_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !reset) req_ready = grant;
    rsp_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (state_q == IDLE && |req_ready) begin
        a_q   <= a_sel;
        b_q   <= b_sel;
        cin_q <= cin_sel;
        id_q  <= grant_idx;
        k_q   <= '0;
        ptr_q <= ptr_nxt;
      end
      if (state_q == BUSY) begin
        sum_q[k_q] <= add_sum;
        carry_q    <= add_cout;
        k_q        <= k_q + KW'(1);
      end
    end
  end

  // After the last word the registered carry is the carry-out of the full add.
  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = carry_q;

endmodule

// File: doc/ks_adder_share_ctrl.md
# ks_adder_share_ctrl

Sequential controller that shares the team's single 32-bit Kogge-Stone adder (`n_bit_pg_Kogge_Stone_A`) among several requesters. It arbitrates round-robin, accepts one multi-word add at a time, runs it word-serially through the adder with a registered carry chain, and returns a tagged result over a valid/ready handshake. It sits between requesting datapath blocks and the adder instance it owns.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `WORDS`, 2: operand length in 32-bit words (1..4); operand width `W = 32*WORDS`.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- `req_b`  in  NREQ*W  operand B, same packing.
- `req_cin`  in  NREQ  carry-in per requester.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_id`  out  $clog2(NREQ)  index of requester that owns the result.
- `rsp_sum`  out  W  sum.
- `rsp_cout`  out  1  carry-out of the full W-bit add.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Arithmetic: {rsp_cout, rsp_sum} = req_a + req_b + req_cin, modulo 2^(W+1).
- FSM states IDLE, BUSY, DONE.
- IDLE: combinational round-robin grant over `req_valid` starting at pointer `ptr`; `req_ready[g]` high for granted g only. Handshake on `req_valid[g] & req_ready[g]`: capture A, B, cin, id=g; word counter k=0; `ptr <= (g+1) mod NREQ`; go BUSY. No valid: stay IDLE, ptr unchanged.
- BUSY: adder inputs = word k of captured A/B; adder Cin = captured cin for k=0, else registered carry from word k-1. Result word k and adder Cout registered each cycle; k increments. After word WORDS-1: go DONE.
- DONE: `rsp_valid`=1 with `rsp_id`, `rsp_sum`, `rsp_cout` stable; on `rsp_valid & rsp_ready` go IDLE. `req_ready` all zero in BUSY and DONE.
- Requesters hold valid and operands stable until accepted; controller does not sample unaccepted inputs.
- Reset values: state IDLE, `ptr`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `busy`=0; `req_ready` forced 0 while `reset` high.
- Reset mid-operation: in-flight request discarded, no response ever issued for it; next cycle is IDLE with ptr=0.
- Valid dropped on the accept edge does not matter; the request is already captured.

## Timing
- Accept at edge E0; word k registered at E(k+1); `rsp_valid` high in the cycle after E(WORDS), i.e. WORDS cycles after the accept edge.
- DONE lasts at least 1 cycle; IDLE lasts at least 1 cycle between requests.
- Minimum request period is WORDS+2 cycles.
- Adder path is combinational within one cycle; no output depends combinationally on `rsp_ready`.
- `req_ready` depends combinationally on `req_valid`, `ptr` and state only.

## Structure
- Package `ks_ctrl_pkg`: `ADDER_W`=32, state enum `ks_state_t` {IDLE, BUSY, DONE}, id-width helper.
- Sub-module `rr_arbiter` (`NREQ` parameter; inputs `req`, `ptr`; outputs one-hot `grant` and `grant_idx`).
- One instance of `n_bit_pg_Kogge_Stone_A` inside the controller; word select by k-indexed part-select.

## Test plan
- WORDS=2, requester 1 alone: A=0x00000000_FFFFFFFF, B=1, cin=0 -> rsp_id=1, rsp_sum=0x00000001_00000000, rsp_cout=0, `rsp_valid` exactly 2 cycles after accept.
- Overflow: A=all ones, B=0, cin=1 -> rsp_sum=0, rsp_cout=1; A=B=all ones, cin=1 -> rsp_sum=all ones, rsp_cout=1.
- Fairness: all 4 `req_valid` held high with `rsp_ready`=1 -> grant order 0,1,2,3,0,1; exactly one `req_ready` bit high per accept; accepts 4 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles in DONE -> outputs stable, `busy`=1, no `req_ready` asserted; then `rsp_ready`=1 -> IDLE next cycle.
- Reset in BUSY (k=1): `reset` for 1 cycle -> `rsp_valid`=0, `busy`=0 next cycle, no response for the aborted request, next grant goes to lowest valid index from 0.
- Random: 10k random operands, requesters, and ready stalls against a scoreboard model of A+B+cin per id -> zero mismatches, no lost or duplicated responses.
